multi_clock_gen: RTL and testbench

MULTI_CLOCK_GEN -- requirements
Module: multi_clock_gen

---
 rtl/multi_clock_gen.sv | 123 ++++++++++++
 tb/tb_multi_clock_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multi_clock_gen.sv
// multi_clock_gen: per-channel square-wave generators programmed in Hz through a serial restoring divider.
// Define MULTI_CLOCK_GEN_SYNC_EN to add a sync input that phase-aligns all enabled channels.
module multi_clock_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SYS_HZ = 100_000_000
) (
    input  logic                                      clock,
    input  logic                                      reset,
`ifdef MULTI_CLOCK_GEN_SYNC_EN
    input  logic                                      sync,
`endif
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                          cfg_freq,
    output logic [NUM_CH-1:0]                         clk_out,
    output logic [NUM_CH-1:0]                         tick,
    output logic [NUM_CH-1:0]                         ch_en
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(SYS_HZ);
    typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;
    state_t state_q, state_d;
    logic rdy_q;
    logic [CH_W-1:0] ch_q, ch_d;
    logic zero_q, zero_d;
    logic [CNT_W:0] div_q, div_d, rem_sh;
    logic [CNT_W-1:0] rem_q, rem_d, quo_q, quo_d, q_half;
    logic [SW-1:0] step_q, step_d;
    logic accept, take, sync_w;
`ifdef MULTI_CLOCK_GEN_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif
    assign cfg_ready = rdy_q;
    assign accept = cfg_valid && rdy_q;
    // quotient bits shift in at the bottom while dividend bits shift out of the top
    assign rem_sh = {rem_q, quo_q[CNT_W-1]};
    assign take = rem_sh >= div_q;
    assign q_half = (quo_q == '0) ? '0 : quo_q - 1'b1;
    always_comb begin
        state_d = state_q;
        ch_d = ch_q;
        zero_d = zero_q;
        div_d = div_q;
        rem_d = rem_q;
        quo_d = quo_q;
        step_d = step_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = (cfg_freq == '0) ? LOAD : DIV;
                ch_d = cfg_ch;
                zero_d = cfg_freq == '0;
                div_d = {cfg_freq, 1'b0};
                rem_d = '0;
                quo_d = DIVIDEND;
                step_d = '0;
            end
            DIV: begin
                rem_d = CNT_W'(take ? rem_sh - div_q : rem_sh);
                quo_d = {quo_q[CNT_W-2:0], take};
                step_d = step_q + 1'b1;
                state_d = (step_q == SW'(CNT_W - 1)) ? LOAD : DIV;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q <= 1'b0;
            ch_q <= '0;
            zero_q <= 1'b0;
            div_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            step_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q <= state_d == IDLE;
            ch_q <= ch_d;
            zero_q <= zero_d;
            div_q <= div_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            step_q <= step_d;
        end
    end
    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] half_q, half_d, cnt_q, cnt_d;
        logic clk_q, clk_d, en_q, en_d, ld, wrap, hold;
        assign ld = state_q == LOAD && ch_q == CH_W'(i);
        assign wrap = cnt_q == half_q;
        // a load, a disabled channel or a sync pulse all park the counter at phase zero
        assign hold = ld || !en_q || sync_w;
        assign tick[i] = en_q && wrap && !ld && !sync_w;
        assign clk_out[i] = clk_q;
        assign ch_en[i] = en_q;
        always_comb begin
            half_d = (ld && !zero_q) ? q_half : half_q;
            en_d = ld ? !zero_q : en_q;
            cnt_d = (hold || wrap) ? '0 : cnt_q + 1'b1;
            clk_d = hold ? 1'b0 : clk_q ^ wrap;
        end
        always_ff @(posedge clock) begin
            if (reset) begin
                half_q <= '0;
                cnt_q <= '0;
                clk_q <= 1'b0;
                en_q <= 1'b0;
            end else begin
                half_q <= half_d;
                cnt_q <= cnt_d;
                clk_q <= clk_d;
                en_q <= en_d;
            end
        end
    end
endmodule

// File: tb/tb_multi_clock_gen.sv
// tb_multi_clock_gen: directed checks of multi_clock_gen at SYS_HZ=1000, plus a 3-channel copy fed
// the same requests so that channel index 3 is out of range for it.
module tb_multi_clock_gen;
    logic clock, reset, cfg_valid, cfg_ready, r3, sync;
    logic [1:0] cfg_ch;
    logic [31:0] cfg_freq;
    logic [3:0] clk_out, tick, ch_en;
    logic [2:0] co3, tk3, en3;
    int vec = 0, errs = 0;
    int lat, n, last, bad, ntk, last3, bad3, ntk3, r0, r1;

    multi_clock_gen #(.NUM_CH(4), .CNT_W(32), .SYS_HZ(1000)) dut (
        .clock(clock), .reset(reset),
`ifdef MULTI_CLOCK_GEN_SYNC_EN
        .sync(sync),
`endif
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_freq(cfg_freq),
        .clk_out(clk_out), .tick(tick), .ch_en(ch_en)
    );
    multi_clock_gen #(.NUM_CH(3), .CNT_W(32), .SYS_HZ(1000)) u3 (
        .clock(clock), .reset(reset),
`ifdef MULTI_CLOCK_GEN_SYNC_EN
        .sync(sync),
`endif
        .cfg_valid(cfg_valid), .cfg_ready(r3), .cfg_ch(cfg_ch), .cfg_freq(cfg_freq),
        .clk_out(co3), .tick(tk3), .ch_en(en3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [31:0] f, output int l);
        int w = 0;
        while (!cfg_ready && w < 100) begin step(1); w++; end
        cfg_valid = 1'b1; cfg_ch = ch; cfg_freq = f;
        step(1);
        cfg_valid = 1'b0;
        l = 1;
        while (!cfg_ready && l < 100) begin step(1); l++; end
    endtask

    task automatic next_tick(input int i, output int k);
        k = 0;
        do begin step(1); k++; end while (!tick[i] && k < 200);
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_freq = '0; sync = 1'b0;
        step(3);
        chk("reset ready", cfg_ready, 0);
        chk("reset outputs", {clk_out, tick, ch_en}, 0);
        reset = 1'b0;
        step(1);
        chk("ready after reset", cfg_ready, 1);
        // basic divide: 1000/(2*100) = 5 -> half 4, period 10
        do_cfg(0, 100, lat);
        chk("ch0 latency", lat, 34);
        chk("ch0 enabled", ch_en, 4'b0001);
        chk("ch0 starts low", clk_out[0], 0);
        next_tick(0, n);
        chk("ch0 first tick", n, 4);
        next_tick(0, n);
        chk("ch0 tick gap", n, 5);
        chk("ch0 high at 2nd tick", clk_out[0], 1);
        step(1);
        chk("ch0 low after 2nd tick", clk_out[0], 0);
        // clamping: q=1 and q=0 both give half 0
        do_cfg(1, 500, lat);
        chk("ch1 f500 latency", lat, 34);
        chk("ch1 f500 c1", {clk_out[1], tick[1]}, 2'b01);
        step(1);
        chk("ch1 f500 c2", {clk_out[1], tick[1]}, 2'b11);
        step(1);
        chk("ch1 f500 c3", {clk_out[1], tick[1]}, 2'b01);
        do_cfg(1, 1000, lat);
        chk("ch1 f1000 c1", {clk_out[1], tick[1]}, 2'b01);
        step(1);
        chk("ch1 f1000 c2", {clk_out[1], tick[1]}, 2'b11);
        step(1);
        chk("ch1 f1000 c3", {clk_out[1], tick[1]}, 2'b01);
        // disable: ch2 at period 20, then freq 0
        do_cfg(2, 50, lat);
        next_tick(2, n);
        chk("ch2 first tick", n, 9);
        next_tick(2, n);
        chk("ch2 tick gap", n, 10);
        do_cfg(2, 0, lat);
        chk("ch2 disable latency", lat, 2);
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            if ({clk_out[2], tick[2], ch_en[2]} != 3'b000) bad++;
            step(1);
        end
        chk("ch2 stays off", bad, 0);
        chk("u3 enables", en3, 3'b011);
        // isolation: ch0 tick spacing across a ch3 reconfiguration; index 3 is out of range for u3
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_freq = 25;
        last = -1; bad = 0; ntk = 0; last3 = -1; bad3 = 0; ntk3 = 0;
        for (int c = 0; c < 60; c++) begin
            step(1);
            cfg_valid = 1'b0;
            if (tick[0]) begin
                if (last >= 0 && c - last != 5) bad++;
                last = c; ntk++;
            end
            if (tk3[0]) begin
                if (last3 >= 0 && c - last3 != 5) bad3++;
                last3 = c; ntk3++;
            end
        end
        chk("iso ch0 spacing", bad, 0);
        chk("iso ch0 count", ntk, 12);
        chk("iso u3 ch0 spacing", bad3, 0);
        chk("iso u3 ch0 count", ntk3, 12);
        chk("iso enables", ch_en, 4'b1011);
        chk("out-of-range enables", en3, 3'b011);
        chk("out-of-range ready", r3, 1);
        next_tick(3, n);
        next_tick(3, n);
        chk("ch3 tick gap", n, 20);
        // reset in the middle of a division
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_freq = 10;
        step(1);
        cfg_valid = 1'b0;
        step(11);
        reset = 1'b1;
        step(1);
        chk("mid reset outputs", {clk_out, tick, ch_en}, 0);
        chk("mid reset ready", cfg_ready, 0);
        chk("mid reset u3", {co3, tk3, en3}, 0);
        reset = 1'b0;
        step(1);
        chk("ready after mid reset", cfg_ready, 1);
        step(40);
        chk("aborted request", ch_en, 0);
`ifdef MULTI_CLOCK_GEN_SYNC_EN
        do_cfg(0, 100, lat);
        do_cfg(1, 250, lat);
        step(7);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync clears", clk_out[1:0], 2'b00);
        r0 = -1; r1 = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (clk_out[0] && r0 < 0) r0 = k;
            if (clk_out[1] && r1 < 0) r1 = k;
        end
        chk("sync ch0 rise", r0, 5);
        chk("sync ch1 rise", r1, 2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
